// File: rtl/fetch_pc_gen_pkg.sv
// Shared types for the fetch PC sequencer: address type, pending-table and
// output-queue entry layouts.
package fetch_pc_gen_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [ADDR_W-1:0] addr;

    typedef struct packed {
        addr  pc;
        logic kill;
    } fetch_entry_t;

    typedef struct packed {
        addr         pc;
        logic [31:0] instr;
    } fetched_t;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Bundle of the redirect, instruction-memory and decode handshakes seen by the
// fetch PC sequencer. master = the sequencer, slave = its environment.
interface fetch_pc_gen_if
    import fetch_pc_gen_pkg::*;
();

    logic        redirect_valid;
    addr         redirect_target;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    addr         req_addr;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        out_valid;
    logic        out_ready;
    addr         out_pc;
    logic [31:0] out_instr;

    modport master (
        input  redirect_valid, redirect_target, req_ready, resp_valid, resp_instr, out_ready,
        output flush, req_valid, req_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_target, req_ready, resp_valid, resp_instr, out_ready,
        input  flush, req_valid, req_addr, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/fetch_pc_gen_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; exposes storage indices so callers
// can keep per-entry side state aligned with the stored data.
module fetch_pc_gen_sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  T              wdata,
    input  logic          pop,
    output T              rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] wr_idx,
    output logic [AW-1:0] rd_idx
);

    logic [AW:0] wptr_q, rptr_q;
    T            mem_q [DEPTH];

    assign wr_idx = wptr_q[AW-1:0];
    assign rd_idx = rptr_q[AW-1:0];
    assign count  = wptr_q - rptr_q;
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wr_idx == rd_idx);
    assign rdata  = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push && !full) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC sequencer: issues in-order fetches under a credit limit, pairs
// responses with their PCs, and squashes wrong-path work on a redirect.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int unsigned XLEN         = ADDR_W,
    parameter addr         RESET_VECTOR = 32'h8000_0000,
    parameter int unsigned DEPTH        = 4
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_gen_if.master bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e           state_q, state_d;
    addr              pc_q, pc_d;
    logic [DEPTH-1:0] kill_q, kill_d;
    addr              target_aligned;
    logic             req_valid, req_fire;

    addr              pend_pc;
    logic [AW:0]      pend_count;
    logic             pend_full, pend_empty, pend_pop;
    logic [AW-1:0]    pend_wr_idx, pend_rd_idx;
    fetch_entry_t     pend_head;

    fetched_t         outq_wdata, outq_rdata;
    logic [AW:0]      outq_count;
    logic             outq_full, outq_empty, outq_push, outq_pop;
    logic [AW-1:0]    outq_wr_idx, outq_rd_idx;
    logic             unused_outq_idx;

    assign target_aligned = {bus.redirect_target[XLEN-1:2], 2'b00};

    // Requests plus buffered responses never exceed DEPTH, so a response
    // always has room in the output queue.
    assign req_valid = !rst && ((32'(pend_count) + 32'(outq_count)) < DEPTH);
    assign req_fire  = req_valid && bus.req_ready;

    assign pend_pop  = bus.resp_valid && !pend_empty;
    assign pend_head = '{pc: pend_pc, kill: kill_q[pend_rd_idx]};

    assign outq_push  = pend_pop && !pend_head.kill;
    assign outq_wdata = '{pc: pend_head.pc, instr: bus.resp_instr};
    assign outq_pop   = bus.out_valid && bus.out_ready;

    assign bus.req_valid = req_valid;
    assign bus.req_addr  = pc_q;
    assign bus.out_valid = !rst && !outq_empty;
    assign bus.out_pc    = outq_rdata.pc;
    assign bus.out_instr = outq_rdata.instr;

    assign unused_outq_idx = ^{outq_wr_idx, outq_rd_idx};

    fetch_pc_gen_sync_fifo #(
        .T     (addr),
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk    (clk),
        .rst    (rst),
        .clear  (1'b0),
        .push   (req_fire),
        .wdata  (pc_q),
        .pop    (pend_pop),
        .rdata  (pend_pc),
        .count  (pend_count),
        .full   (pend_full),
        .empty  (pend_empty),
        .wr_idx (pend_wr_idx),
        .rd_idx (pend_rd_idx)
    );

    fetch_pc_gen_sync_fifo #(
        .T     (fetched_t),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.redirect_valid),
        .push   (outq_push),
        .wdata  (outq_wdata),
        .pop    (outq_pop),
        .rdata  (outq_rdata),
        .count  (outq_count),
        .full   (outq_full),
        .empty  (outq_empty),
        .wr_idx (outq_wr_idx),
        .rd_idx (outq_rd_idx)
    );

    always_comb begin
        pc_d   = pc_q;
        kill_d = kill_q;
        if (req_fire) begin
            pc_d                = pc_q + addr'(INSTR_BYTES);
            kill_d[pend_wr_idx] = 1'b0;
        end
        // Marking every slot also covers an entry accepted this same cycle.
        if (bus.redirect_valid) begin
            pc_d   = target_aligned;
            kill_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_VECTOR;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   state_d = bus.redirect_valid ? StFlush : StRun;
            StFlush: state_d = bus.redirect_valid ? StFlush : StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        bus.flush = !rst && (state_q == StFlush);
    end

`ifndef SYNTHESIS
    resp_needs_pending: assert property (@(posedge clk) disable iff (rst)
        bus.resp_valid |-> !pend_empty);
    redirect_word_aligned: assert property (@(posedge clk) disable iff (rst)
        bus.redirect_valid |-> (bus.redirect_target[1:0] == 2'b00));
    pend_no_overflow: assert property (@(posedge clk) disable iff (rst)
        req_fire |-> !pend_full);
    outq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        outq_push |-> !outq_full);
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: memory model with optional hold, scoreboard
// of expected {pc, instr} drained by an independent output monitor.
module tb_fetch_pc_gen;
    import fetch_pc_gen_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_gen_if bus ();

    fetch_pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h8000_0000),
        .DEPTH        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       checks   = 0;
    int       failures = 0;
    fetched_t sb[$];
    addr      mem_q[$];
    logic     mem_hold = 1'b0;

    function automatic logic [31:0] mem_word(addr a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expect_out(addr pc);
        sb.push_back('{pc: pc, instr: mem_word(pc)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst                 = 1'b1;
        bus.req_ready       = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.out_ready       = 1'b1;
        mem_hold            = 1'b0;
        #1;
        check("rst_req_valid_comb", 32'(bus.req_valid), 0);
        step();
        step();
        #1;
        check("rst_req_valid", 32'(bus.req_valid), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_flush", 32'(bus.flush), 0);
        rst = 1'b0;
    endtask

    // Memory: one-cycle latency, in order, responses held back while mem_hold.
    initial begin
        logic next_v;
        addr  next_a;
        next_v         = 1'b0;
        next_a         = '0;
        bus.resp_valid = 1'b0;
        bus.resp_instr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_q.delete();
                next_v = 1'b0;
            end else begin
                if (bus.req_valid && bus.req_ready) mem_q.push_back(bus.req_addr);
                next_v = !mem_hold && (mem_q.size() > 0);
                if (next_v) next_a = mem_q.pop_front();
            end
            @(posedge clk);
            #1;
            bus.resp_valid = next_v;
            bus.resp_instr = next_v ? mem_word(next_a) : 32'h0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got pc %h, want no output", bus.out_pc);
                end else begin
                    fetched_t e;
                    e = sb.pop_front();
                    check("out_pc", bus.out_pc, e.pc);
                    check("out_instr", bus.out_instr, e.instr);
                end
            end
        end
    end

    initial begin
        int   acc;
        logic last_v;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.req_ready       = 1'b0;
        bus.out_ready       = 1'b0;

        // Straight-line fetch after reset.
        do_reset();
        expect_out(32'h8000_0000);
        expect_out(32'h8000_0004);
        expect_out(32'h8000_0008);
        bus.req_ready = 1'b1;
        #1;
        check("t1_req_valid", 32'(bus.req_valid), 1);
        check("t1_addr0", bus.req_addr, 32'h8000_0000);
        step(); #1;
        check("t1_addr1", bus.req_addr, 32'h8000_0004);
        step(); #1;
        check("t1_addr2", bus.req_addr, 32'h8000_0008);
        step();
        bus.req_ready = 1'b0;
        repeat (6) begin
            step(); #1;
            check("t1_flush", 32'(bus.flush), 0);
        end
        check("t1_drain", sb.size(), 0);

        // Credit limit with decode stalled.
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_ready = 1'b1;
        acc    = 0;
        last_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.req_valid) acc++;
            last_v = bus.req_valid;
            step();
        end
        check("t2_accepted", acc, 4);
        check("t2_stalled", 32'(last_v), 0);
        expect_out(32'h8000_0000);
        expect_out(32'h8000_0004);
        expect_out(32'h8000_0008);
        expect_out(32'h8000_000C);
        bus.req_ready = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("t2_out_valid", 32'(bus.out_valid), 1);
        step(); #1;
        check("t2_req_valid_after_pop", 32'(bus.req_valid), 1);
        check("t2_addr_after_pop", bus.req_addr, 32'h8000_0010);
        repeat (6) step();
        check("t2_drain", sb.size(), 0);

        // Redirect with two requests in flight.
        do_reset();
        mem_hold      = 1'b1;
        bus.req_ready = 1'b1;
        step();
        step();
        bus.req_ready       = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h8000_0100;
        step();
        bus.redirect_valid = 1'b0;
        bus.req_ready      = 1'b1;
        expect_out(32'h8000_0100);
        #1;
        check("t3_flush", 32'(bus.flush), 1);
        check("t3_req_valid", 32'(bus.req_valid), 1);
        check("t3_addr", bus.req_addr, 32'h8000_0100);
        step();
        bus.req_ready = 1'b0;
        mem_hold      = 1'b0;
        #1;
        check("t3_flush_drop", 32'(bus.flush), 0);
        repeat (3) begin
            step(); #1;
            check("t3_squashed", 32'(bus.out_valid), 0);
        end
        step(); #1;
        check("t3_out_valid", 32'(bus.out_valid), 1);
        repeat (4) step();
        check("t3_drain", sb.size(), 0);

        // Redirect in the same cycle as a request handshake.
        do_reset();
        expect_out(32'h8000_0000);
        expect_out(32'h8000_0004);
        expect_out(32'h8000_0100);
        bus.req_ready = 1'b1;
        step();
        step();
        step();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h8000_0100;
        #1;
        check("t4_addr_n", bus.req_addr, 32'h8000_000C);
        check("t4_req_valid_n", 32'(bus.req_valid), 1);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("t4_flush", 32'(bus.flush), 1);
        check("t4_req_valid", 32'(bus.req_valid), 1);
        check("t4_addr", bus.req_addr, 32'h8000_0100);
        step();
        bus.req_ready = 1'b0;
        #1;
        check("t4_flush_drop", 32'(bus.flush), 0);
        repeat (5) step();
        check("t4_drain", sb.size(), 0);

        // Back-to-back redirects: the later one wins.
        do_reset();
        expect_out(32'h8000_0200);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h8000_0100;
        step();
        bus.redirect_target = 32'h8000_0200;
        bus.req_ready       = 1'b1;
        #1;
        check("t5_flush1", 32'(bus.flush), 1);
        check("t5_addr1", bus.req_addr, 32'h8000_0100);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("t5_flush2", 32'(bus.flush), 1);
        check("t5_addr2", bus.req_addr, 32'h8000_0200);
        step();
        bus.req_ready = 1'b0;
        #1;
        check("t5_flush3", 32'(bus.flush), 0);
        repeat (5) step();
        check("t5_drain", sb.size(), 0);

        // Reset pulse with three entries buffered.
        do_reset();
        bus.out_ready = 1'b0;
        bus.req_ready = 1'b1;
        step();
        step();
        step();
        bus.req_ready = 1'b0;
        step(); #1;
        check("t6_buffered", 32'(bus.out_valid), 1);
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_req_valid", 32'(bus.req_valid), 0);
        check("t6_rst_out_valid", 32'(bus.out_valid), 0);
        check("t6_rst_flush", 32'(bus.flush), 0);
        step();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_ready = 1'b1;
        expect_out(32'h8000_0000);
        #1;
        check("t6_out_cleared", 32'(bus.out_valid), 0);
        check("t6_req_valid", 32'(bus.req_valid), 1);
        check("t6_addr", bus.req_addr, 32'h8000_0000);
        step();
        bus.req_ready = 1'b0;
        repeat (5) step();
        check("t6_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Front-end PC sequencer. Owns the architectural fetch PC and issues in-order fetch requests to instruction memory.
- Matches memory responses back to their PCs and hands {pc, instr} to the decode stage over a valid/ready handshake.
- Closes the loop with the execution units by consuming their branch-redirect output (br_valid/br_target from exec_result).
- On a redirect it restarts fetch at the target, raises flush to the back end, and squashes everything fetched down the wrong path.

Parameters:
- XLEN, 32, width of addresses and the PC; equals the width of the addr typedef.
- RESET_VECTOR, 32'h8000_0000, PC fetched first after reset.
- DEPTH, 4, maximum number of requests in flight plus buffered responses; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- redirect_valid  in  1  taken branch/jump resolved in exec this cycle
- redirect_target  in  XLEN  new fetch PC
- flush  out  1  one-cycle squash pulse to decode/exec
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  fetch address, word aligned
- resp_valid  in  1  instruction returned; in order, no backpressure
- resp_instr  in  32  returned instruction word
- out_valid  out  1  fetched instruction available to decode
- out_ready  in  1  decode accepts
- out_pc  out  XLEN  PC of the instruction
- out_instr  out  32  instruction word

Behaviour:
- Reset (rst high at a clock edge):
  - pc = RESET_VECTOR; pending table and output queue emptied.
  - flush = 0, req_valid = 0, out_valid = 0 while rst is high.
  - First request goes out in the cycle after rst deasserts.
- Credit rule:
  - req_valid = !rst && (pending_count + outq_count < DEPTH).
  - Because of this rule a response always finds room in the output queue.
- Request handshake:
  - On req_valid && req_ready, push {pc, kill=0} into the pending FIFO and set pc += 4.
  - req_addr = pc combinationally.
- Response:
  - On resp_valid, pop the pending FIFO head.
  - kill=0: push {pc, instr} into the output queue in the same cycle.
  - kill=1: drop the response silently.
  - resp_valid with the pending FIFO empty is a protocol error; assert in simulation and ignore in RTL.
- Output:
  - out_* reflect the output queue head; pop on out_valid && out_ready.
  - Latency from response to out_valid is 1 cycle when the queue is empty (registered queue).
- Redirect, asserted in cycle N:
  - Edge N→N+1: pc = redirect_target; kill bit set on every pending entry, including one accepted in cycle N; output queue cleared, including any push in cycle N.
  - Cycle N+1: flush = 1 for exactly one cycle; req_valid may be asserted with req_addr = redirect_target.
  - A redirect overrides pc += 4 in the same cycle.
- Back-to-back redirects in N and N+1: the last one wins; flush is high in N+1 and N+2.
- redirect_target[1:0] != 0: low bits are forced to zero; assert in simulation.
- State machine (flush bookkeeping):
  - States: RUN, FLUSH.
  - RUN→FLUSH on redirect_valid.
  - FLUSH→RUN unless redirect_valid; FLUSH→FLUSH on redirect_valid.
  - flush = (state == FLUSH).
- Wrap-around: the PC wraps modulo 2^XLEN. The FIFO pointers are DEPTH-sized with an extra wrap bit for full/empty.
- rst mid-operation: all in-flight state is discarded. Memory responses arriving after reset are treated as protocol errors; the integration guarantees memory is reset too.

Decomposition:
- Shared package (types.sv): addr typedef (already present); fetch_entry_t {addr pc; logic kill;}; fetched_t {addr pc; logic [31:0] instr;}; constant INSTR_BYTES = 4.
- Sub-module sync_fifo #(type T, DEPTH): synchronous FIFO with push, pop, clear, count, full/empty. Instantiated twice, for the pending table and the output queue. Kill marking needs per-entry writes, so the pending FIFO is instead a kill-bit vector alongside the generic FIFO.

Test Plan:
- Reset release, req_ready=1, memory returns 1 cycle later, out_ready=1 → out_pc sequence 8000_0000, 8000_0004, 8000_0008; flush stays 0.
- req_ready=1, out_ready=0, DEPTH=4 → exactly 4 requests accepted, then req_valid=0 until the first out pop; after one pop req_valid=1 next cycle with addr 8000_0010.
- Two requests in flight, redirect_valid with target 8000_0100 → flush=1 one cycle later; the next 2 responses are dropped (out_valid stays 0); the next delivered out_pc = 8000_0100.
- Redirect in the same cycle as a request handshake at 8000_000C → that response is dropped; req_addr = 8000_0100 in cycle N+1.
- Redirects to 100 then 200 in consecutive cycles → flush high 2 cycles; the first delivered out_pc = 200.
- rst pulsed with 3 entries queued → out_valid=0 next cycle; the first request after release is 8000_0000.
